acq_window_sequencer: RTL and testbench
=======================================

Name: acq_window_sequencer

Overview:
- Sequences the APES count-acquisition cycle: clears the pulse counters, opens a programmable integration window, and signals collection complete.
- Then hands the count bus to the rocket readout and waits for readout completion or a timeout before starting the next window.
- Sits between the instrument command/config logic and the count-readout datapath; drives cnt_clr, cnt_start, collect_done and en_rocket_rd, and consumes rdout_done.

Parameters:
- CLR_CYCLES, 4, number of cycles cnt_clr is held high per window (must be ≥1).
- INTEG_W, 24, width of integ_len and of the integration timer.
- RD_TIMEOUT, 5000000, maximum cycles spent in READOUT (100 ms at 50 MHz); must be ≥2.
- FRAME_W, 16, width of frame_cnt.
- ERR_W, 8, width of timeout_cnt.

Ports:
- clk50  in  1  50 MHz system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level; 1 = run continuous acquisition.
- integ_len  in  INTEG_W  integration length in clk50 cycles, sampled on CLEAR entry.
- rdout_done  in  1  pulse from the count readout: all words shifted out.
- status_clr  in  1  pulse; clears timeout_flag and timeout_cnt.
- cnt_clr  out  1  counter clear, high during CLEAR.
- cnt_start  out  1  counter gate, high during INTEG.
- collect_done  out  1  one-cycle pulse at the end of a window.
- en_rocket_rd  out  1  high during READOUT.
- frame_cnt  out  FRAME_W  completed windows, wraps modulo 2^FRAME_W.
- timeout_flag  out  1  sticky; set on a readout timeout.
- timeout_cnt  out  ERR_W  count of readout timeouts, saturating.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock; every flop is reset synchronously by rst=1. All outputs are registered Moore decodes of the state register.
- Reset values: state IDLE, all 1-bit outputs 0, frame_cnt 0, timeout_cnt 0, timers 0.
- States and transitions:
  - IDLE: all strobes low. enable=1 → CLEAR.
  - CLEAR: cnt_clr=1 for exactly CLR_CYCLES cycles. On entry, latch win_len = integ_len; if integ_len=0, latch 1. After CLR_CYCLES → INTEG.
  - INTEG: cnt_start=1 for exactly win_len cycles (timer runs 0..win_len-1). Then → LATCH.
  - LATCH: single cycle; collect_done=1; frame_cnt increments, wrapping from 2^FRAME_W-1 to 0. Always → READOUT.
  - READOUT: en_rocket_rd=1; a readout timer counts from 0.
    - rdout_done=1 → CLEAR if enable=1, else IDLE.
    - Timer reaching RD_TIMEOUT-1 without rdout_done: set timeout_flag, timeout_cnt+1 (saturates at all-ones), then the same exit rule.
- Abort: enable=0 while in CLEAR or INTEG → IDLE next cycle. No collect_done pulse; frame_cnt is unchanged; cnt_start/cnt_clr fall one cycle later (registered).
- enable=0 during LATCH or READOUT has no effect until the readout exits. A started readout is never abandoned except by timeout.
- rdout_done outside READOUT is ignored.
- rdout_done in the same cycle as timer expiry counts as done: no timeout is recorded.
- status_clr clears timeout_flag and timeout_cnt. If status_clr coincides with a timeout event, the timeout wins: flag=1, cnt=1.
- Changes to integ_len mid-window have no effect until the next CLEAR entry.
- rst mid-operation returns to IDLE with all outputs deasserted on the next edge. frame_cnt and timeout_cnt are zeroed.
- Cycle budget per window, back-to-back: CLR_CYCLES + win_len + 1 + readout duration.

Decomposition:
- Shared package apes_pkg holds:
  - the state encoding typedef (IDLE, CLEAR, INTEG, LATCH, READOUT);
  - the default constants CLR_CYCLES_DEF and RD_TIMEOUT_DEF;
  - the clock-rate constant CLK_HZ = 50_000_000.
- One natural sub-module: window_timer, a loadable down-counter with a terminal-count flag. It is instantiated twice, for the CLEAR/INTEG timing and for the READOUT timeout.

Test Plan:
- Reset then enable=1, integ_len=10, CLR_CYCLES=4:
  - cnt_clr high 4 cycles, then cnt_start high exactly 10 cycles, then a 1-cycle collect_done;
  - frame_cnt=1 and en_rocket_rd high from the next cycle.
- rdout_done pulse 20 cycles into READOUT with enable=1 → next cycle CLEAR (cnt_clr=1, en_rocket_rd=0). Two full windows → frame_cnt=2.
- integ_len=0 → cnt_start high exactly 1 cycle. enable=0 at INTEG cycle 3 of 10 → IDLE, no collect_done, frame_cnt unchanged.
- RD_TIMEOUT=50, rdout_done never asserted → READOUT lasts 50 cycles, timeout_flag=1, timeout_cnt=1. rdout_done coinciding with cycle 50 → no timeout recorded.
- Timeout and status_clr in the same cycle → flag=1, cnt=1. Saturation: 260 timeouts with ERR_W=8 → timeout_cnt=255.
- rst=1 mid-INTEG → next edge: all outputs 0, state IDLE, counters 0. frame_cnt wrap with FRAME_W=2: fifth window → frame_cnt=1.

Source files
------------

// File: rtl/apes_pkg.sv
// Shared definitions for the APES count-acquisition sequencer: state encoding
// and default timing constants.
package apes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_INTEG   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_READOUT = 3'd4
    } acq_state_t;

    localparam int CLK_HZ         = 50_000_000;
    localparam int CLR_CYCLES_DEF = 4;
    // 100 ms readout budget
    localparam int RD_TIMEOUT_DEF = CLK_HZ / 10;

endpackage

// File: rtl/window_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so loading
// N-1 gives a phase that lasts exactly N cycles.
module window_timer #(
    parameter int W = 24
) (
    input  logic         clk50,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk50) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/acq_window_sequencer.sv
// Acquisition window sequencer: CLEAR -> INTEG -> LATCH -> READOUT, repeating
// while enable is high, with readout timeout accounting.
module acq_window_sequencer
    import apes_pkg::*;
#(
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int INTEG_W    = 24,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF,
    parameter int FRAME_W    = 16,
    parameter int ERR_W      = 8
) (
    input  logic               clk50,
    input  logic               rst,
    input  logic               enable,
    input  logic [INTEG_W-1:0] integ_len,
    input  logic               rdout_done,
    input  logic               status_clr,
    output logic               cnt_clr,
    output logic               cnt_start,
    output logic               collect_done,
    output logic               en_rocket_rd,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               timeout_flag,
    output logic [ERR_W-1:0]   timeout_cnt,
    output logic               busy,
    output logic [2:0]         dbg_state
);

    localparam int RD_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [INTEG_W-1:0] CLR_LOAD = INTEG_W'(CLR_CYCLES - 1);
    localparam logic [RD_W-1:0]    RD_LOAD  = RD_W'(RD_TIMEOUT - 1);

    // Readout handshake: en_rocket_rd grants the count bus to the readout;
    // rdout_done is a single-cycle completion pulse honoured only in READOUT,
    // and the bus is withdrawn the cycle after done or after the timeout.

    acq_state_t         state, state_next;
    logic [INTEG_W-1:0] win_len;
    logic               ph_load, ph_tc;
    logic [INTEG_W-1:0] ph_val;
    logic               rd_load, rd_tc;
    logic               timeout_ev;
    logic               clear_entry;

    window_timer #(.W(INTEG_W)) u_phase_timer (
        .clk50    (clk50),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .tc       (ph_tc)
    );

    window_timer #(.W(RD_W)) u_rd_timer (
        .clk50    (clk50),
        .rst      (rst),
        .load     (rd_load),
        .load_val (RD_LOAD),
        .tc       (rd_tc)
    );

    always_ff @(posedge clk50) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ph_load    = 1'b0;
        ph_val     = '0;
        rd_load    = 1'b0;
        timeout_ev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_CLEAR;
                    ph_load    = 1'b1;
                    ph_val     = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (ph_tc) begin
                    state_next = ST_INTEG;
                    ph_load    = 1'b1;
                    ph_val     = win_len - INTEG_W'(1);
                end
            end
            ST_INTEG: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (ph_tc) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_next = ST_READOUT;
                rd_load    = 1'b1;
            end
            ST_READOUT: begin
                // done wins over a coincident expiry
                if (rdout_done || rd_tc) begin
                    timeout_ev = !rdout_done;
                    if (enable) begin
                        state_next = ST_CLEAR;
                        ph_load    = 1'b1;
                        ph_val     = CLR_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign clear_entry = (state_next == ST_CLEAR) && (state != ST_CLEAR);

    always_ff @(posedge clk50) begin
        if (rst) begin
            win_len <= '0;
        end else if (clear_entry) begin
            win_len <= (integ_len == '0) ? INTEG_W'(1) : integ_len;
        end
    end

    // Strobes are registered from the next state so they align with state.
    always_ff @(posedge clk50) begin
        if (rst) begin
            cnt_clr      <= 1'b0;
            cnt_start    <= 1'b0;
            collect_done <= 1'b0;
            en_rocket_rd <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cnt_clr      <= (state_next == ST_CLEAR);
            cnt_start    <= (state_next == ST_INTEG);
            collect_done <= (state_next == ST_LATCH);
            en_rocket_rd <= (state_next == ST_READOUT);
            busy         <= (state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == ST_LATCH) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            timeout_flag <= 1'b0;
            timeout_cnt  <= '0;
        end else if (timeout_ev) begin
            timeout_flag <= 1'b1;
            if (status_clr) begin
                timeout_cnt <= ERR_W'(1);
            end else if (timeout_cnt != '1) begin
                timeout_cnt <= timeout_cnt + ERR_W'(1);
            end
        end else if (status_clr) begin
            timeout_flag <= 1'b0;
            timeout_cnt  <= '0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_acq_window_sequencer.sv
// Directed bench for acq_window_sequencer with CLR_CYCLES=4, RD_TIMEOUT=50,
// FRAME_W=2, ERR_W=8; expected values are hand-computed cycle positions.
module tb_acq_window_sequencer;
    import apes_pkg::*;

    localparam int INTEG_W = 8;
    localparam int FRAME_W = 2;
    localparam int ERR_W   = 8;

    logic               clk50;
    logic               rst;
    logic               enable;
    logic [INTEG_W-1:0] integ_len;
    logic               rdout_done;
    logic               status_clr;
    logic               cnt_clr;
    logic               cnt_start;
    logic               collect_done;
    logic               en_rocket_rd;
    logic [FRAME_W-1:0] frame_cnt;
    logic               timeout_flag;
    logic [ERR_W-1:0]   timeout_cnt;
    logic               busy;
    logic [2:0]         dbg_state;
    logic [4:0]         strobes;

    int n_vec = 0;
    int n_err = 0;

    acq_window_sequencer #(
        .CLR_CYCLES (4),
        .INTEG_W    (INTEG_W),
        .RD_TIMEOUT (50),
        .FRAME_W    (FRAME_W),
        .ERR_W      (ERR_W)
    ) dut (
        .clk50        (clk50),
        .rst          (rst),
        .enable       (enable),
        .integ_len    (integ_len),
        .rdout_done   (rdout_done),
        .status_clr   (status_clr),
        .cnt_clr      (cnt_clr),
        .cnt_start    (cnt_start),
        .collect_done (collect_done),
        .en_rocket_rd (en_rocket_rd),
        .frame_cnt    (frame_cnt),
        .timeout_flag (timeout_flag),
        .timeout_cnt  (timeout_cnt),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // {cnt_clr, cnt_start, collect_done, en_rocket_rd, busy}
    assign strobes = {cnt_clr, cnt_start, collect_done, en_rocket_rd, busy};

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; integ_len = '0; rdout_done = 1'b0; status_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        n_vec++;
        if (strobes !== 5'b00000) begin
            n_err++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 5'b00000);
        end
        n_vec++;
        if (dbg_state !== 3'(ST_IDLE) || frame_cnt !== 2'd0 || timeout_cnt !== 8'd0 || timeout_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs got state=%0d frame=%0d tcnt=%0d tflag=%b exp 0/0/0/0",
                     dbg_state, frame_cnt, timeout_cnt, timeout_flag);
        end
    endtask

    task automatic test_basic_window;
        logic [4:0] exp;
        enable = 1'b1; integ_len = 8'd10;
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            if (c <= 4)       exp = 5'b10001;
            else if (c <= 14) exp = 5'b01001;
            else if (c == 15) exp = 5'b00101;
            else              exp = 5'b00011;
            n_vec++;
            if (strobes !== exp) begin
                n_err++; $display("FAIL basic_seq cycle=%0d got=%b exp=%b", c, strobes, exp);
            end
        end
        n_vec++;
        if (frame_cnt !== 2'd1) begin
            n_err++; $display("FAIL basic_frame got=%0d exp=1", frame_cnt);
        end
        // readout cycle 1 now; pulse done during readout cycle 20
        tick(19);
        rdout_done = 1'b1;
        tick(1);
        rdout_done = 1'b0;
        n_vec++;
        if (strobes !== 5'b10001 || timeout_flag !== 1'b0) begin
            n_err++; $display("FAIL done_to_clear got=%b tflag=%b exp=10001 tflag=0", strobes, timeout_flag);
        end
        tick(15);
        n_vec++;
        if (strobes !== 5'b00011 || frame_cnt !== 2'd2) begin
            n_err++; $display("FAIL second_window got=%b frame=%0d exp=00011 frame=2", strobes, frame_cnt);
        end
        enable = 1'b0; rdout_done = 1'b1;
        tick(1);
        rdout_done = 1'b0;
        n_vec++;
        if (strobes !== 5'b00000 || dbg_state !== 3'(ST_IDLE) || frame_cnt !== 2'd2) begin
            n_err++;
            $display("FAIL done_to_idle got=%b state=%0d frame=%0d exp=00000 state=0 frame=2",
                     strobes, dbg_state, frame_cnt);
        end
        rdout_done = 1'b1;
        tick(1);
        rdout_done = 1'b0;
        n_vec++;
        if (dbg_state !== 3'(ST_IDLE)) begin
            n_err++; $display("FAIL done_outside_readout got state=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_zero_len_and_abort;
        logic [4:0] exp;
        enable = 1'b1; integ_len = 8'd0;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            if (c <= 4)       exp = 5'b10001;
            else if (c == 5)  exp = 5'b01001;
            else if (c == 6)  exp = 5'b00101;
            else              exp = 5'b00011;
            n_vec++;
            if (strobes !== exp) begin
                n_err++; $display("FAIL zero_len cycle=%0d got=%b exp=%b", c, strobes, exp);
            end
        end
        n_vec++;
        if (frame_cnt !== 2'd3) begin
            n_err++; $display("FAIL zero_len_frame got=%0d exp=3", frame_cnt);
        end
        integ_len = 8'd10; rdout_done = 1'b1;
        tick(1);
        rdout_done = 1'b0;
        tick(6);
        n_vec++;
        if (strobes !== 5'b01001) begin
            n_err++; $display("FAIL abort_pre got=%b exp=01001", strobes);
        end
        enable = 1'b0;
        tick(1);
        n_vec++;
        if (strobes !== 5'b00000 || dbg_state !== 3'(ST_IDLE) || frame_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL abort got=%b state=%0d frame=%0d exp=00000 state=0 frame=3",
                     strobes, dbg_state, frame_cnt);
        end
        tick(1);
        n_vec++;
        if (collect_done !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done got=%b exp=0", collect_done);
        end
    endtask

    task automatic test_timeout;
        enable = 1'b1; integ_len = 8'd1;
        tick(7);
        n_vec++;
        if (strobes !== 5'b00011 || frame_cnt !== 2'd0) begin
            n_err++; $display("FAIL to_start got=%b frame=%0d exp=00011 frame=0", strobes, frame_cnt);
        end
        tick(48);
        n_vec++;
        if (timeout_flag !== 1'b0 || en_rocket_rd !== 1'b1) begin
            n_err++; $display("FAIL to_c49 got tflag=%b rd=%b exp tflag=0 rd=1", timeout_flag, en_rocket_rd);
        end
        enable = 1'b0;
        tick(1);
        n_vec++;
        if (en_rocket_rd !== 1'b1) begin
            n_err++; $display("FAIL to_c50 got rd=%b exp=1", en_rocket_rd);
        end
        tick(1);
        n_vec++;
        if (strobes !== 5'b00000 || timeout_flag !== 1'b1 || timeout_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL to_event got=%b tflag=%b tcnt=%0d exp=00000 tflag=1 tcnt=1",
                     strobes, timeout_flag, timeout_cnt);
        end
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        n_vec++;
        if (timeout_flag !== 1'b0 || timeout_cnt !== 8'd0) begin
            n_err++; $display("FAIL status_clr got tflag=%b tcnt=%0d exp 0/0", timeout_flag, timeout_cnt);
        end
        enable = 1'b1;
        tick(1);
        tick(55);
        rdout_done = 1'b1;
        tick(1);
        rdout_done = 1'b0;
        n_vec++;
        if (strobes !== 5'b10001 || timeout_flag !== 1'b0 || timeout_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL done_at_expiry got=%b tflag=%b tcnt=%0d exp=10001 tflag=0 tcnt=0",
                     strobes, timeout_flag, timeout_cnt);
        end
    endtask

    task automatic test_timeout_vs_clr;
        tick(56);
        n_vec++;
        if (strobes !== 5'b10001 || timeout_cnt !== 8'd1) begin
            n_err++; $display("FAIL back_to_back_to got=%b tcnt=%0d exp=10001 tcnt=1", strobes, timeout_cnt);
        end
        tick(55);
        status_clr = 1'b1; enable = 1'b0;
        tick(1);
        status_clr = 1'b0;
        n_vec++;
        if (timeout_flag !== 1'b1 || timeout_cnt !== 8'd1 || dbg_state !== 3'(ST_IDLE)) begin
            n_err++;
            $display("FAIL to_vs_clr got tflag=%b tcnt=%0d state=%0d exp tflag=1 tcnt=1 state=0",
                     timeout_flag, timeout_cnt, dbg_state);
        end
    endtask

    task automatic test_saturation;
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        enable = 1'b1;
        tick(1);
        tick(260 * 56 - 1);
        n_vec++;
        if (timeout_cnt !== 8'd255 || en_rocket_rd !== 1'b1) begin
            n_err++; $display("FAIL sat_pre got tcnt=%0d rd=%b exp tcnt=255 rd=1", timeout_cnt, en_rocket_rd);
        end
        enable = 1'b0;
        tick(1);
        n_vec++;
        if (timeout_cnt !== 8'd255 || timeout_flag !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL saturation got tcnt=%0d tflag=%b busy=%b exp tcnt=255 tflag=1 busy=0",
                     timeout_cnt, timeout_flag, busy);
        end
    endtask

    task automatic test_reset_mid;
        enable = 1'b1; integ_len = 8'd10;
        tick(6);
        n_vec++;
        if (strobes !== 5'b01001) begin
            n_err++; $display("FAIL mid_integ_pre got=%b exp=01001", strobes);
        end
        rst = 1'b1; enable = 1'b0;
        tick(1);
        rst = 1'b0;
        n_vec++;
        if (strobes !== 5'b00000 || dbg_state !== 3'(ST_IDLE) || frame_cnt !== 2'd0 ||
            timeout_cnt !== 8'd0 || timeout_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got=%b state=%0d frame=%0d tcnt=%0d tflag=%b exp all 0",
                     strobes, dbg_state, frame_cnt, timeout_cnt, timeout_flag);
        end
    endtask

    task automatic test_frame_wrap;
        logic [FRAME_W-1:0] exp_frame;
        enable = 1'b1; integ_len = 8'd1;
        tick(1);
        for (int k = 1; k <= 5; k++) begin
            tick(6);
            exp_frame = FRAME_W'(k % 4);
            n_vec++;
            if (frame_cnt !== exp_frame || en_rocket_rd !== 1'b1) begin
                n_err++;
                $display("FAIL frame_wrap window=%0d got frame=%0d rd=%b exp frame=%0d rd=1",
                         k, frame_cnt, en_rocket_rd, exp_frame);
            end
            if (k == 5) enable = 1'b0;
            rdout_done = 1'b1;
            tick(1);
            rdout_done = 1'b0;
        end
        n_vec++;
        if (dbg_state !== 3'(ST_IDLE) || frame_cnt !== 2'd1) begin
            n_err++; $display("FAIL frame_wrap_end got state=%0d frame=%0d exp state=0 frame=1", dbg_state, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_zero_len_and_abort();
        test_timeout();
        test_timeout_vs_clr();
        test_saturation();
        test_reset_mid();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
